datapoint_stream_reader: RTL and testbench

DATAPOINT_STREAM_READER -- requirements
Module: datapoint_stream_reader

---
 rtl/datapoint_stream_reader.sv | 169 ++++++++++++++++
 tb/tb_datapoint_stream_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datapoint_stream_reader.sv
// Burst reader: fetches a run of datapoints from a 1-cycle synchronous memory and streams them
// through a small FIFO to the neuron array with valid/ready flow control.
module datapoint_stream_reader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ADDR_W-1:0] io_baseAddr,
  input  logic [ADDR_W:0]   io_count,
  input  logic              io_abort,
  output logic              io_busy,
  output logic              io_done,
  output logic [ADDR_W-1:0] io_memAddr,
  output logic              io_memWrEna,
  input  logic [DATA_W-1:0] io_memRdData,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [DATA_W-1:0] io_out_data,
  output logic              io_out_last
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   accepted_q, accepted_d;
  logic              inflight_q;
  logic              done_q, done_d;

  logic [DATA_W-1:0] fifo_q [BUF_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]   occ_q;

  logic              issue, pop, push, flush, last_beat, has_room;
  logic [ADDR_W-1:0] issue_addr;
  logic [OccW:0]     pending, limit;

  assign io_out_valid = (occ_q != '0);
  assign io_out_data  = fifo_q[rd_ptr_q];
  assign pop          = io_out_valid & io_out_ready;
  assign last_beat    = io_out_valid && (accepted_q == count_q - (ADDR_W+1)'(1));
  assign io_out_last  = last_beat;
  assign io_busy      = (state_q != StIdle);
  assign io_done      = done_q;
  assign io_memWrEna  = 1'b0;
  // The address is presented in the issue cycle itself so the first beat is valid two cycles
  // after io_start; otherwise it holds the last issued address.
  assign io_memAddr   = issue_addr;

  // Reserve a FIFO slot for every read in flight, crediting a beat leaving this cycle.
  assign pending  = {1'b0, occ_q} + {{OccW{1'b0}}, inflight_q};
  assign limit    = (OccW+1)'(BUF_DEPTH) + {{OccW{1'b0}}, pop};
  assign has_room = (pending < limit);

  assign push = inflight_q & ~flush;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_addr = addr_q;
    flush      = 1'b0;
    if (state_q != StIdle && io_abort) begin
      state_d = StIdle;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (io_start && !io_abort) begin
            if (io_count == '0) begin
              done_d = 1'b1;
            end else begin
              state_d    = StRun;
              base_d     = io_baseAddr;
              count_d    = io_count;
              accepted_d = '0;
              issue      = has_room;
              issue_addr = has_room ? io_baseAddr : addr_q;
              issued_d   = (ADDR_W+1)'(has_room);
            end
          end
        end
        StRun, StDrain: begin
          if (state_q == StRun) begin
            if (issued_q == count_q) begin
              state_d = StDrain;
            end else if (has_room) begin
              issue      = 1'b1;
              issue_addr = base_q + issued_q[ADDR_W-1:0];
              issued_d   = issued_q + (ADDR_W+1)'(1);
            end
          end
          if (pop) begin
            accepted_d = accepted_q + (ADDR_W+1)'(1);
            if (last_beat) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      addr_q     <= issue_addr;
      count_q    <= count_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      inflight_q <= issue;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= io_memRdData;
        wr_ptr_q <= (wr_ptr_q == PtrW'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + OccW'(1);
        2'b01:   occ_q <= occ_q - OccW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_datapoint_stream_reader.sv
// Directed bench for datapoint_stream_reader: memory word k holds value k, cycle 0 is the
// cycle io_start is high, outputs are sampled 3 ns after each rising edge.
module tb_datapoint_stream_reader;

  logic        clock;
  logic        reset;
  logic        io_start;
  logic [9:0]  io_baseAddr;
  logic [10:0] io_count;
  logic        io_abort;
  logic        io_busy;
  logic        io_done;
  logic [9:0]  io_memAddr;
  logic        io_memWrEna;
  logic [17:0] io_memRdData;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [17:0] io_out_data;
  logic        io_out_last;

  logic [17:0] mem [1024];
  int          n_asserts;
  int          n_fail;

  datapoint_stream_reader #(
    .ADDR_W   (10),
    .DATA_W   (18),
    .BUF_DEPTH(2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_start    (io_start),
    .io_baseAddr (io_baseAddr),
    .io_count    (io_count),
    .io_abort    (io_abort),
    .io_busy     (io_busy),
    .io_done     (io_done),
    .io_memAddr  (io_memAddr),
    .io_memWrEna (io_memWrEna),
    .io_memRdData(io_memRdData),
    .io_out_valid(io_out_valid),
    .io_out_ready(io_out_ready),
    .io_out_data (io_out_data),
    .io_out_last (io_out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) io_memRdData <= mem[io_memAddr];

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_asserts    = 0;
    n_fail       = 0;
    for (int k = 0; k < 1024; k++) mem[k] = 18'(k);
    reset        = 1'b0;
    io_start     = 1'b0;
    io_baseAddr  = '0;
    io_count     = '0;
    io_abort     = 1'b0;
    io_out_ready = 1'b0;
    #2;
    chk("rst_busy", io_busy, 0);
    chk("rst_done", io_done, 0);
    chk("rst_valid", io_out_valid, 0);
    chk("rst_last", io_out_last, 0);
    chk("rst_addr", io_memAddr, 0);
    chk("rst_data", io_out_data, 0);
    chk("rst_wrena", io_memWrEna, 0);
    repeat (2) cyc();
    @(negedge clock);
    reset = 1'b1;
    cyc();

    // Basic burst: base 5, count 4, ready held high.
    cyc(); io_start = 1; io_baseAddr = 10'd5; io_count = 11'd4; io_out_ready = 1; #2;
    chk("t1_c0_addr", io_memAddr, 5);
    chk("t1_c0_busy", io_busy, 0);
    cyc(); io_start = 0; #2;
    chk("t1_c1_busy", io_busy, 1);
    chk("t1_c1_valid", io_out_valid, 0);
    chk("t1_c1_addr", io_memAddr, 6);
    cyc(); #2;
    chk("t1_c2_valid", io_out_valid, 1);
    chk("t1_c2_data", io_out_data, 5);
    chk("t1_c2_last", io_out_last, 0);
    cyc(); #2;
    chk("t1_c3_data", io_out_data, 6);
    chk("t1_c3_wrena", io_memWrEna, 0);
    cyc(); #2;
    chk("t1_c4_data", io_out_data, 7);
    chk("t1_c4_last", io_out_last, 0);
    cyc(); #2;
    chk("t1_c5_data", io_out_data, 8);
    chk("t1_c5_last", io_out_last, 1);
    chk("t1_c5_done", io_done, 0);
    cyc(); #2;
    chk("t1_c6_done", io_done, 1);
    chk("t1_c6_busy", io_busy, 0);
    chk("t1_c6_valid", io_out_valid, 0);
    cyc(); #2;
    chk("t1_c7_done", io_done, 0);

    // Address wrap: base 1022, count 4.
    cyc(); io_start = 1; io_baseAddr = 10'd1022; io_count = 11'd4; #2;
    chk("t2_c0_addr", io_memAddr, 1022);
    cyc(); io_start = 0; #2;
    chk("t2_c1_addr", io_memAddr, 1023);
    cyc(); #2;
    chk("t2_c2_addr", io_memAddr, 0);
    chk("t2_c2_data", io_out_data, 1022);
    cyc(); #2;
    chk("t2_c3_addr", io_memAddr, 1);
    chk("t2_c3_data", io_out_data, 1023);
    cyc(); #2;
    chk("t2_c4_data", io_out_data, 0);
    chk("t2_c4_last", io_out_last, 0);
    cyc(); #2;
    chk("t2_c5_data", io_out_data, 1);
    chk("t2_c5_last", io_out_last, 1);
    cyc(); #2;
    chk("t2_c6_done", io_done, 1);
    cyc();

    // Backpressure: count 3, ready high on every third cycle.
    cyc(); io_start = 1; io_baseAddr = 10'd20; io_count = 11'd3; io_out_ready = 1; #2;
    chk("t3_c0_addr", io_memAddr, 20);
    cyc(); io_start = 0; io_out_ready = 0; #2;
    chk("t3_c1_addr", io_memAddr, 21);
    cyc(); #2;
    chk("t3_c2_valid", io_out_valid, 1);
    chk("t3_c2_data", io_out_data, 20);
    chk("t3_c2_addr_hold", io_memAddr, 21);
    cyc(); io_out_ready = 1; #2;
    chk("t3_c3_data", io_out_data, 20);
    chk("t3_c3_addr", io_memAddr, 22);
    cyc(); io_out_ready = 0; #2;
    chk("t3_c4_data", io_out_data, 21);
    cyc(); #2;
    chk("t3_c5_data", io_out_data, 21);
    chk("t3_c5_last", io_out_last, 0);
    cyc(); io_out_ready = 1; #2;
    chk("t3_c6_data", io_out_data, 21);
    cyc(); io_out_ready = 0; #2;
    chk("t3_c7_data", io_out_data, 22);
    chk("t3_c7_last", io_out_last, 1);
    cyc(); #2;
    chk("t3_c8_data", io_out_data, 22);
    chk("t3_c8_last", io_out_last, 1);
    chk("t3_c8_done", io_done, 0);
    cyc(); io_out_ready = 1; #2;
    chk("t3_c9_valid", io_out_valid, 1);
    cyc(); #2;
    chk("t3_c10_done", io_done, 1);
    chk("t3_c10_valid", io_out_valid, 0);

    // Zero-length burst.
    cyc(); io_start = 1; io_baseAddr = 10'd3; io_count = 11'd0; #2;
    chk("t4_c0_busy", io_busy, 0);
    cyc(); io_start = 0; #2;
    chk("t4_c1_done", io_done, 1);
    chk("t4_c1_busy", io_busy, 0);
    chk("t4_c1_valid", io_out_valid, 0);
    cyc(); #2;
    chk("t4_c2_done", io_done, 0);
    chk("t4_c2_valid", io_out_valid, 0);

    // Abort after three beats, then start+abort together, then a fresh one-beat burst.
    cyc(); io_start = 1; io_baseAddr = 10'd100; io_count = 11'd10; #2;
    cyc(); io_start = 0; #2;
    cyc(); #2;
    chk("t5_b0", io_out_data, 100);
    cyc(); #2;
    chk("t5_b1", io_out_data, 101);
    cyc(); #2;
    chk("t5_b2", io_out_data, 102);
    cyc(); io_out_ready = 0; io_abort = 1; #2;
    chk("t5_c5_valid", io_out_valid, 1);
    chk("t5_c5_data", io_out_data, 103);
    cyc(); io_abort = 0; #2;
    chk("t5_c6_valid", io_out_valid, 0);
    chk("t5_c6_busy", io_busy, 0);
    chk("t5_c6_done", io_done, 0);
    cyc(); io_start = 1; io_abort = 1; io_baseAddr = 10'd0; io_count = 11'd1; #2;
    chk("t5_c7_done", io_done, 0);
    chk("t5_c7_valid", io_out_valid, 0);
    cyc(); io_start = 0; io_abort = 0; io_out_ready = 1; #2;
    chk("t5_sa_busy", io_busy, 0);
    chk("t5_sa_done", io_done, 0);
    cyc(); io_start = 1; #2;
    chk("t5_n0_addr", io_memAddr, 0);
    cyc(); io_start = 0; #2;
    chk("t5_n1_valid", io_out_valid, 0);
    cyc(); #2;
    chk("t5_n2_valid", io_out_valid, 1);
    chk("t5_n2_data", io_out_data, 0);
    chk("t5_n2_last", io_out_last, 1);
    cyc(); #2;
    chk("t5_n3_done", io_done, 1);
    cyc();

    // Start ignored while busy, then reset during DRAIN.
    cyc(); io_start = 1; io_baseAddr = 10'd50; io_count = 11'd2; io_out_ready = 0; #2;
    cyc(); io_baseAddr = 10'd7; io_count = 11'd5; #2;
    chk("t6_c1_addr", io_memAddr, 51);
    cyc(); io_start = 0; #2;
    chk("t6_c2_busy", io_busy, 1);
    chk("t6_c2_addr", io_memAddr, 51);
    chk("t6_c2_data", io_out_data, 50);
    cyc(); #2;
    chk("t6_c3_valid", io_out_valid, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", io_busy, 0);
    chk("t6_rst_valid", io_out_valid, 0);
    chk("t6_rst_last", io_out_last, 0);
    chk("t6_rst_addr", io_memAddr, 0);
    chk("t6_rst_data", io_out_data, 0);
    chk("t6_rst_done", io_done, 0);
    io_out_ready = 1;
    cyc();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #2;
      chk("t6_post_valid", io_out_valid, 0);
      chk("t6_post_busy", io_busy, 0);
      chk("t6_post_done", io_done, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
